axis_uart_tx_m2s: RTL and testbench
===================================

Name: axis_uart_tx_m2s

Overview:
AXI-Stream slave that accepts 32-bit words and serializes each one onto a single UART TX line as four 8N1 frames.
Byte 0 (TDATA[7:0]) is sent first and byte 3 last, so the four frames unpack in the same order the UART-to-AXIS receive path packs them.
It forms the transmit half of the UART/AXI-Stream bridge on the PL side, so the PS can drive a serial link through a DMA stream.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (115200 baud at 100 MHz); legal range 2..1023.
BYTES_PER_WORD, 4, bytes serialized per accepted word; fixed at 4 in this revision.

Ports:
S_AXIS_ACLK  input  1  single clock; every register is on its rising edge.
S_AXIS_ARESET  input  1  synchronous reset, active-high.
S_AXIS_TVALID  input  1  upstream word valid.
S_AXIS_TREADY  output  1  block can accept a word; registered.
S_AXIS_TDATA  input  32  word to transmit; byte 0 = [7:0].
dout  output  1  UART serial line; idles high; registered.
tx_busy  output  1  high from word acceptance until the final stop bit completes.

Behaviour:
- Reset values (S_AXIS_ARESET=1 at an edge): state=IDLE, dout=1, S_AXIS_TREADY=0, tx_busy=0, all counters=0, word register=0. Reset has priority over every other event.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - S_AXIS_TREADY<=1; dout held at 1.
  - Handshake = S_AXIS_TVALID & S_AXIS_TREADY sampled at edge k.
  - At edge k: word<=S_AXIS_TDATA, byte_idx<=0, div<=0, S_AXIS_TREADY<=0, tx_busy<=1, dout<=0, state->START.
- Bit timing:
  - div counts 0..CLKS_PER_BIT-1; each bit is held on dout for exactly CLKS_PER_BIT cycles.
  - A bit ends when div==CLKS_PER_BIT-1; div wraps to 0 at that edge.
- START: at end of bit: dout<=word[8*byte_idx+0], bit_idx<=0, state->DATA.
- DATA: at end of bit:
  - if bit_idx<7: bit_idx++, dout<=next bit. Bits go out LSB first.
  - if bit_idx==7: dout<=1, state->STOP.
- STOP: at end of bit:
  - if byte_idx<3: byte_idx++, dout<=0, state->START. Next frame follows with no gap.
  - if byte_idx==3: state->IDLE, tx_busy<=0, S_AXIS_TREADY<=1.
- Latency:
  - dout falls at edge k and first becomes low in the cycle after edge k.
  - S_AXIS_TREADY rises at edge k+40*CLKS_PER_BIT.
  - Earliest next handshake is edge k+40*CLKS_PER_BIT+1, so there is exactly 1 extra idle-high cycle between back-to-back words.
- While busy:
  - S_AXIS_TVALID and S_AXIS_TDATA are ignored.
  - TDATA changes after acceptance have no effect; the word register alone drives dout.
- S_AXIS_TVALID dropping without a handshake is tolerated; no error is flagged.
- Reset mid-frame: the word is discarded and dout returns to 1 at the reset edge. There is no partial-frame completion.
- First cycle after reset release: state is IDLE and S_AXIS_TREADY becomes 1 at the next edge.
- No combinational path from any input to any output.

Test Plan:
1. Reset behaviour: hold reset 3 cycles -> dout=1, S_AXIS_TREADY=0, tx_busy=0. After release, S_AXIS_TREADY=1 by the second edge.
2. Single word: CLKS_PER_BIT=8, send TDATA=0x44332211 -> dout carries frames 0x11, 0x22, 0x33, 0x44.
   - Each frame is start 0, 8 bits LSB-first, stop 1, 8 cycles per bit.
   - S_AXIS_TREADY returns high exactly 320 cycles after the handshake edge.
3. Back-to-back words: TVALID held high with 0xA5A5A5A5 then 0x0000FF00 -> 8 frames decode correctly.
   - Exactly 1 idle-high cycle between the two words.
   - Second handshake lands 321 cycles after the first.
4. Data change while busy: change TDATA to 0xDEADBEEF 5 cycles after accepting 0x12345678 -> transmitted bytes are still 0x78, 0x56, 0x34, 0x12.
5. Reset mid-frame: assert reset during bit 3 of byte 1 -> dout=1 on the next cycle, tx_busy=0, no further falling edges until a new handshake.
6. Loopback: CLKS_PER_BIT=868, dout wired to the receive path's din, 3 random words -> the receive path outputs identical 32-bit words.

Source files
------------

// File: rtl/axis_uart_tx_m2s.sv
// axis_uart_tx_m2s: AXI-Stream slave that serializes each 32-bit word as four 8N1 UART frames, byte 0 first.
module axis_uart_tx_m2s #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic        S_AXIS_ACLK,
  input  logic        S_AXIS_ARESET,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  output logic        dout,
  output logic        tx_busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);
  state_t      state_q, state_d;
  logic [9:0]  div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] word_q, word_d;
  logic        dout_q, dout_d, rdy_q, rdy_d, busy_q, busy_d;
  logic        bit_end;
  assign bit_end       = div_q == LAST;
  assign S_AXIS_TREADY = rdy_q;
  assign dout          = dout_q;
  assign tx_busy       = busy_q;
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      dout_q  <= 1'b1;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end
  // The registered word alone feeds dout, so TDATA is free to change once accepted.
  always_comb begin
    state_d = state_q;
    div_d   = (state_q == IDLE || bit_end) ? '0 : div_q + 10'd1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    dout_d  = dout_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        rdy_d  = 1'b1;
        dout_d = 1'b1;
        if (S_AXIS_TVALID && rdy_q) begin
          word_d  = S_AXIS_TDATA;
          byte_d  = '0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          dout_d  = 1'b0;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        dout_d  = word_q[{byte_q, 3'd0}];
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        if (bit_q != 3'd7) begin
          bit_d  = bit_q + 3'd1;
          dout_d = word_q[{byte_q, bit_q + 3'd1}];
        end else begin
          dout_d  = 1'b1;
          state_d = STOP;
        end
      end
      STOP: if (bit_end) begin
        if (byte_q != 2'd3) begin
          byte_d  = byte_q + 2'd1;
          dout_d  = 1'b0;
          state_d = START;
        end else begin
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axis_uart_tx_m2s.sv
// tb_axis_uart_tx_m2s: checks the UART serializer against a per-cycle waveform model of four 8N1 frames.
module tb_axis_uart_tx_m2s;
  localparam int C = 8;
  logic clk = 1'b0, rst = 1'b1, tvalid = 1'b0;
  logic [31:0] tdata = '0;
  logic tready, dout, busy;
  int cyc = 0, tests = 0, fails = 0, hs_cyc = 0;

  axis_uart_tx_m2s #(.CLKS_PER_BIT(C)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready), .S_AXIS_TDATA(tdata), .dout(dout), .tx_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line level for each of the 40 bit slots of a word, in transmission order.
  function automatic logic [39:0] frames(input logic [31:0] w);
    logic [39:0] v;
    for (int f = 0; f < 4; f++) v[10*f +: 10] = {1'b1, w[8*f +: 8], 1'b0};
    return v;
  endfunction

  task automatic handshake(input logic [31:0] w, output bit ok);
    int n = 0;
    tdata = w;
    tvalid = 1'b1;
    ok = 1'b0;
    while (tready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (tready === 1'b1) begin @(posedge clk); #1; hs_cyc = cyc; ok = 1'b1; end
  endtask

  task automatic check_word(input logic [31:0] w, input bit keep, input logic [31:0] nxt, input int chg_at);
    logic [39:0] want, obs;
    bit ok, ctl_ok = 1'b1;
    int bad = -1;
    handshake(w, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL handshake w=%h: tready never seen high", w); return; end
    tvalid = keep;
    want = frames(w);
    obs = '0;
    for (int t = 0; t < 40*C; t++) begin
      if (t == chg_at) tdata = nxt;
      if (t % C == C/2) obs[t/C] = dout;
      if (dout !== want[t/C] && bad < 0) bad = t;
      if (tready !== 1'b0 || busy !== 1'b1) ctl_ok = 1'b0;
      @(posedge clk); #1;
    end
    tests++;
    if (bad >= 0) begin fails++; $display("FAIL waveform w=%h: first bad cycle %0d, bits got %h want %h", w, bad, obs, want); end
    tests++;
    if (!ctl_ok) begin fails++; $display("FAIL busy_ctl w=%h: tready/tx_busy wrong during transmit", w); end
    tests++;
    if (tready !== 1'b1 || busy !== 1'b0 || dout !== 1'b1) begin
      fails++;
      $display("FAIL end_of_word w=%h: at +%0d tready=%b busy=%b dout=%b, want 1 0 1", w, cyc - hs_cyc, tready, busy, dout);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (dout !== 1'b1 || tready !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_vals: dout=%b tready=%b busy=%b, want 1 0 0", dout, tready, busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (tready !== 1'b1) begin fails++; $display("FAIL reset_release: tready=%b want 1", tready); end
  endtask

  task automatic test_single;
    check_word(32'h44332211, 1'b0, 32'h0, 0);
  endtask

  task automatic test_back_to_back;
    int first;
    check_word(32'hA5A5A5A5, 1'b1, 32'h0000FF00, 0);
    first = hs_cyc;
    check_word(32'h0000FF00, 1'b0, 32'h0, 0);
    tests++;
    if (hs_cyc - first !== 40*C + 1) begin
      fails++; $display("FAIL b2b_gap: handshake spacing %0d want %0d", hs_cyc - first, 40*C + 1);
    end
  endtask

  task automatic test_data_change;
    check_word(32'h12345678, 1'b0, 32'hDEADBEEF, 4);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int falls = 0;
    handshake(32'hC3A5_0FF0, ok);
    tvalid = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL mid_handshake: tready never seen high"); return; end
    repeat (14*C + 3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (dout !== 1'b1 || busy !== 1'b0 || tready !== 1'b0) begin
      fails++; $display("FAIL mid_reset: dout=%b busy=%b tready=%b, want 1 0 0", dout, busy, tready);
    end
    rst = 1'b0;
    repeat (100) begin @(posedge clk); #1; if (dout !== 1'b1 || busy !== 1'b0) falls++; end
    tests++;
    if (falls != 0) begin fails++; $display("FAIL mid_quiet: %0d non-idle cycles got, want 0", falls); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      check_word($urandom, 1'b0, $urandom, int'($urandom_range(0, 40*C - 1)));
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_single;
    test_back_to_back;
    test_data_change;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
